// File: rtl/decoder_nm_scan_pkg.sv
// Shared types and helpers for the decoder_nm_scan block.
package decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_BLANK
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Active-low one-cold pattern: bit idx low, all other bits (up to 64) high.
    function automatic logic [63:0] onecold(input int unsigned idx, input int unsigned outs);
        logic [63:0] v;
        v = '1;
        if (idx < outs) begin
            v[idx[5:0]] = 1'b0;
        end
        return v;
    endfunction

endpackage

// File: rtl/decoder_nm_scan_if.sv
// Address/strobe bundle between a controller (master) and the decoder (slave).
interface decoder_nm_scan_if #(
    parameter int unsigned AW = 2
);
    localparam int unsigned OUTS = 1 << AW;

    logic            cs;
    logic            mode;
    logic [AW-1:0]   addr;
    logic            addr_vld;
    logic            addr_rdy;
    logic [OUTS-1:0] y_n;
    logic [AW-1:0]   sel_idx;
    logic            scan_wrap;

    modport master (
        output cs, mode, addr, addr_vld,
        input  addr_rdy, y_n, sel_idx, scan_wrap
    );

    modport slave (
        input  cs, mode, addr, addr_vld,
        output addr_rdy, y_n, sel_idx, scan_wrap
    );

endinterface

// File: rtl/decoder_nm_scan_dwell_cnt.sv
// Dwell counter for SCAN mode: counts 0..DWELL-1 while enabled, flags the last count.
module decoder_dwell_cnt #(
    parameter int unsigned DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);
    localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [CW-1:0] r_cnt;

    assign o_expire = (r_cnt == CW'(DWELL - 1));

    // Count up while enabled, restart on expiry or explicit clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            if (o_expire) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/decoder_nm_scan.sv
// Registered AW-to-2**AW active-low decoder with DIRECT (valid/ready) and SCAN modes.
// Optional break-before-make blanking is enabled with macro DECODER_BLANK_EN.
module decoder_nm_scan
    import decoder_pkg::*;
#(
    parameter int unsigned AW    = 2,
    parameter int unsigned DWELL = 4
) (
    input  logic               clk,
    input  logic               rst,
    decoder_nm_scan_if.slave   bus
);
    localparam int unsigned OUTS = 1 << AW;

    state_t          r_state, w_state;
    logic [AW-1:0]   r_idx, w_idx;
    logic            r_scan, w_scan;
    logic [OUTS-1:0] r_y_n, w_y_n;
    logic            r_wrap, w_wrap;
    logic            r_rdy, w_rdy;
    logic            w_cnt_clr, w_cnt_en, w_expire, w_accept;

    decoder_dwell_cnt #(.DWELL(DWELL)) u_dwell (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_cnt_clr),
        .i_en     (w_cnt_en),
        .o_expire (w_expire)
    );

    assign w_accept = bus.addr_vld & r_rdy & ~bus.cs & (bus.mode == MODE_DIRECT);
    assign w_scan   = (bus.mode == MODE_SCAN) & ~bus.cs;

    // Next state, next index and counter control; cs overrides everything.
    always_comb begin
        w_state   = r_state;
        w_idx     = r_idx;
        w_wrap    = 1'b0;
        w_cnt_clr = 1'b0;
        w_cnt_en  = 1'b0;
        if (bus.cs) begin
            w_state   = ST_IDLE;
            w_idx     = '0;
            w_cnt_clr = 1'b1;
        end else if (bus.mode == MODE_SCAN) begin
            if (!r_scan) begin
                w_state   = ST_DRIVE;
                w_idx     = '0;
                w_cnt_clr = 1'b1;
            end else begin
                w_cnt_en = 1'b1;
`ifdef DECODER_BLANK_EN
                // Blank cycle already holds the advanced index and is dwell count 0.
                if (r_state == ST_BLANK) begin
                    w_state = ST_DRIVE;
                    w_wrap  = (r_idx == '0);
                end else if (w_expire) begin
                    w_idx = r_idx + AW'(1);
                    // With DWELL=1 a blank would consume every cycle, so strobe directly.
                    if (DWELL > 1) begin
                        w_state = ST_BLANK;
                    end else begin
                        w_wrap = (r_idx == '1);
                    end
                end
`else
                if (w_expire) begin
                    w_idx  = r_idx + AW'(1);
                    w_wrap = (r_idx == '1);
                end
`endif
            end
        end else begin
            if (r_scan) begin
                w_state   = ST_IDLE;
                w_cnt_clr = 1'b1;
            end else if (w_accept) begin
                w_idx = bus.addr;
`ifdef DECODER_BLANK_EN
                w_state = ((r_state == ST_DRIVE) && (bus.addr != r_idx)) ? ST_BLANK : ST_DRIVE;
`else
                w_state = ST_DRIVE;
`endif
            end
`ifdef DECODER_BLANK_EN
            else if (r_state == ST_BLANK) begin
                w_state = ST_DRIVE;
            end
`endif
        end
    end

    // Next values of the registered outputs.
    always_comb begin
        w_y_n = '1;
        if (w_state == ST_DRIVE) begin
            w_y_n = OUTS'(onecold(32'(w_idx), OUTS));
        end
        w_rdy = (w_state != ST_BLANK) & ~bus.cs & (bus.mode == MODE_DIRECT);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_scan  <= 1'b0;
            r_y_n   <= '1;
            r_wrap  <= 1'b0;
            r_rdy   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_idx   <= w_idx;
            r_scan  <= w_scan;
            r_y_n   <= w_y_n;
            r_wrap  <= w_wrap;
            r_rdy   <= w_rdy;
        end
    end

    assign bus.y_n       = r_y_n;
    assign bus.sel_idx   = r_idx;
    assign bus.scan_wrap = r_wrap;
    assign bus.addr_rdy  = r_rdy;

endmodule

// File: tb/tb_decoder_nm_scan.sv
// Directed self-checking bench for decoder_nm_scan (AW=2/DWELL=4, AW=3/DWELL=1, AW=1/DWELL=2).
module tb_decoder_nm_scan;

`ifdef DECODER_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    decoder_nm_scan_if #(.AW(2)) bus_a ();
    decoder_nm_scan_if #(.AW(3)) bus_b ();
    decoder_nm_scan_if #(.AW(1)) bus_c ();

    decoder_nm_scan #(.AW(2), .DWELL(4)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    decoder_nm_scan #(.AW(3), .DWELL(1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
    decoder_nm_scan #(.AW(1), .DWELL(2)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cold invariant on every DUT, every cycle.
    always @(negedge clk) begin
        checks += 3;
        if ($countones(~bus_a.y_n) > 1) begin
            errors++;
            $display("FAIL onecold_a: y_n=%b required at most one low bit", bus_a.y_n);
        end
        if ($countones(~bus_b.y_n) > 1) begin
            errors++;
            $display("FAIL onecold_b: y_n=%b required at most one low bit", bus_b.y_n);
        end
        if ($countones(~bus_c.y_n) > 1) begin
            errors++;
            $display("FAIL onecold_c: y_n=%b required at most one low bit", bus_c.y_n);
        end
    end

    task automatic chk_a(input string name, input logic [3:0] exp_y);
        checks++;
        if (bus_a.y_n !== exp_y) begin
            errors++;
            $display("FAIL %s: y_n=%b required %b", name, bus_a.y_n, exp_y);
        end
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks += 4;
        if (bus_a.y_n !== 4'b1111) begin errors++; $display("FAIL rst_y: y_n=%b required 1111", bus_a.y_n); end
        if (bus_a.addr_rdy !== 1'b0) begin errors++; $display("FAIL rst_rdy: got %b required 0", bus_a.addr_rdy); end
        if (bus_a.scan_wrap !== 1'b0) begin errors++; $display("FAIL rst_wrap: got %b required 0", bus_a.scan_wrap); end
        if (bus_a.sel_idx !== 2'd0) begin errors++; $display("FAIL rst_sel: got %0d required 0", bus_a.sel_idx); end
        rst = 1'b0;
        tick();
        checks++;
        if (bus_a.addr_rdy !== 1'b1) begin errors++; $display("FAIL rdy_after_rst: got %b required 1", bus_a.addr_rdy); end
        bus_a.addr = 2'd1; bus_a.addr_vld = 1'b1;
        tick();
        bus_a.addr_vld = 1'b0;
        chk_a("pre_rst_drive", 4'b1101);
        #2 rst = 1'b1;
        #1;
        chk_a("async_rst_y", 4'b1111);
        checks += 2;
        if (bus_a.addr_rdy !== 1'b0) begin errors++; $display("FAIL async_rst_rdy: got %b required 0", bus_a.addr_rdy); end
        if (bus_a.scan_wrap !== 1'b0) begin errors++; $display("FAIL async_rst_wrap: got %b required 0", bus_a.scan_wrap); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_direct();
        bus_a.addr = 2'd2; bus_a.addr_vld = 1'b1;
        tick();
        bus_a.addr_vld = 1'b0;
        chk_a("direct_y", 4'b1011);
        checks++;
        if (bus_a.sel_idx !== 2'd2) begin errors++; $display("FAIL direct_sel: got %0d required 2", bus_a.sel_idx); end
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_a("direct_hold", 4'b1011);
        end
    endtask

    task automatic test_cs();
        bus_a.cs = 1'b1; bus_a.addr = 2'd3; bus_a.addr_vld = 1'b1;
        tick();
        chk_a("cs_y", 4'b1111);
        checks += 2;
        if (bus_a.sel_idx !== 2'd0) begin errors++; $display("FAIL cs_sel: got %0d required 0", bus_a.sel_idx); end
        if (bus_a.addr_rdy !== 1'b0) begin errors++; $display("FAIL cs_rdy: got %b required 0", bus_a.addr_rdy); end
        tick();
        chk_a("cs_hold", 4'b1111);
        bus_a.cs = 1'b0; bus_a.addr_vld = 1'b0;
        tick();
        chk_a("cs_release", 4'b1111);
        checks++;
        if (bus_a.addr_rdy !== 1'b1) begin errors++; $display("FAIL cs_release_rdy: got %b required 1", bus_a.addr_rdy); end
        repeat (2) begin
            tick();
            chk_a("cs_no_restore", 4'b1111);
        end
        bus_a.addr_vld = 1'b1;
        tick();
        bus_a.addr_vld = 1'b0;
        chk_a("cs_new_accept", 4'b0111);
    endtask

    task automatic test_direct_change();
        bus_a.addr = 2'd1; bus_a.addr_vld = 1'b1;
        tick();
        bus_a.addr_vld = 1'b0;
        tick();
        chk_a("chg_settle_1", 4'b1101);
        bus_a.addr = 2'd3; bus_a.addr_vld = 1'b1;
        tick();
        bus_a.addr_vld = 1'b0;
        chk_a("chg_to_3", BLANK ? 4'b1111 : 4'b0111);
        checks++;
        if (bus_a.addr_rdy !== !BLANK) begin errors++; $display("FAIL chg_rdy: got %b required %b", bus_a.addr_rdy, !BLANK); end
        tick();
        chk_a("chg_settle_3", 4'b0111);
        bus_a.addr_vld = 1'b1;
        tick();
        bus_a.addr_vld = 1'b0;
        chk_a("same_addr_no_blank", 4'b0111);
        checks++;
        if (bus_a.addr_rdy !== 1'b1) begin errors++; $display("FAIL same_addr_rdy: got %b required 1", bus_a.addr_rdy); end
    endtask

    task automatic test_scan();
        logic [3:0] exp_y;
        logic       exp_w;
        int         wraps;
        wraps = 0;
        bus_a.mode = 1'b1;
        tick();
        for (int k = 0; k < 20; k++) begin
            if (k > 0) tick();
            exp_y = (BLANK && (k % 4 == 0) && k > 0) ? 4'b1111 : ~(4'b0001 << ((k / 4) % 4));
            exp_w = BLANK ? ((k % 16 == 1) && k > 1) : ((k % 16 == 0) && k > 0);
            chk_a("scan_y", exp_y);
            checks += 2;
            if (bus_a.scan_wrap !== exp_w) begin
                errors++;
                $display("FAIL scan_wrap k=%0d: got %b required %b", k, bus_a.scan_wrap, exp_w);
            end
            if (bus_a.addr_rdy !== 1'b0) begin
                errors++;
                $display("FAIL scan_rdy k=%0d: got %b required 0", k, bus_a.addr_rdy);
            end
            if (bus_a.scan_wrap === 1'b1) wraps++;
        end
        checks++;
        if (wraps !== 1) begin errors++; $display("FAIL scan_wrap_count: got %0d required 1", wraps); end
    endtask

    task automatic test_mode_switch();
        bus_a.mode = 1'b0;
        tick();
        bus_a.mode = 1'b1;
        tick();
        chk_a("ms_start", 4'b1110);
        repeat (6) tick();
        chk_a("ms_idx1", 4'b1101);
        bus_a.mode = 1'b0;
        tick();
        chk_a("ms_to_direct", 4'b1111);
        checks++;
        if (bus_a.addr_rdy !== 1'b1) begin errors++; $display("FAIL ms_rdy: got %b required 1", bus_a.addr_rdy); end
        bus_a.addr = 2'd0; bus_a.addr_vld = 1'b1;
        tick();
        bus_a.addr_vld = 1'b0;
        chk_a("ms_accept0", 4'b1110);
    endtask

    task automatic test_sweep();
        logic [7:0] exp_b;
        logic [1:0] exp_c;
        logic       exp_wb, exp_wc;
        bus_b.cs = 1'b0; bus_b.mode = 1'b1;
        bus_c.cs = 1'b0; bus_c.mode = 1'b1;
        tick();
        for (int k = 0; k < 18; k++) begin
            if (k > 0) tick();
            exp_b  = ~(8'b0000_0001 << (k % 8));
            exp_wb = (k % 8 == 0) && k > 0;
            exp_c  = (BLANK && (k % 2 == 0) && k > 0) ? 2'b11 : ~(2'b01 << ((k / 2) % 2));
            exp_wc = BLANK ? ((k % 4 == 1) && k > 1) : ((k % 4 == 0) && k > 0);
            checks += 4;
            if (bus_b.y_n !== exp_b) begin errors++; $display("FAIL sweep_b_y k=%0d: got %b required %b", k, bus_b.y_n, exp_b); end
            if (bus_b.scan_wrap !== exp_wb) begin errors++; $display("FAIL sweep_b_wrap k=%0d: got %b required %b", k, bus_b.scan_wrap, exp_wb); end
            if (bus_c.y_n !== exp_c) begin errors++; $display("FAIL sweep_c_y k=%0d: got %b required %b", k, bus_c.y_n, exp_c); end
            if (bus_c.scan_wrap !== exp_wc) begin errors++; $display("FAIL sweep_c_wrap k=%0d: got %b required %b", k, bus_c.scan_wrap, exp_wc); end
        end
        bus_b.mode = 1'b0;
        tick();
        bus_b.addr = 3'd5; bus_b.addr_vld = 1'b1;
        tick();
        bus_b.addr_vld = 1'b0;
        checks += 2;
        if (bus_b.y_n !== 8'b1101_1111) begin errors++; $display("FAIL b_direct_y: got %b required 11011111", bus_b.y_n); end
        if (bus_b.sel_idx !== 3'd5) begin errors++; $display("FAIL b_direct_sel: got %0d required 5", bus_b.sel_idx); end
        bus_b.cs = 1'b1;
        tick();
        checks++;
        if (bus_b.y_n !== 8'hFF) begin errors++; $display("FAIL b_cs_y: got %b required 11111111", bus_b.y_n); end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus_a.cs = 1'b0; bus_a.mode = 1'b0; bus_a.addr = '0; bus_a.addr_vld = 1'b0;
        bus_b.cs = 1'b1; bus_b.mode = 1'b0; bus_b.addr = '0; bus_b.addr_vld = 1'b0;
        bus_c.cs = 1'b1; bus_c.mode = 1'b0; bus_c.addr = '0; bus_c.addr_vld = 1'b0;
        test_reset();
        test_direct();
        test_cs();
        test_direct_change();
        test_scan();
        test_mode_switch();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
